btn_pulse_gen: RTL and testbench

- Parametrised, multi-channel successor to the single-button one-shot.
- Per channel: synchronises an asynchronous button/switch input, debounces it with a counter, and emits a single-cycle pulse on a selectable edge (rise, fall or both).
- Sits between raw board buttons/switches and the password/keypad FSMs.
- Also exposes the clean debounced level and an any-channel pulse flag.

---
 rtl/btn_pulse_pkg.sv | 10 +
 rtl/btn_debounce_ch.sv | 76 +++++++
 rtl/btn_pulse_gen.sv | 44 ++++
 tb/tb_btn_pulse_gen.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pulse_pkg.sv
// btn_pulse_pkg: edge-mode codes and counter sizing shared by btn_pulse_gen
package btn_pulse_pkg;
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel of synchroniser, counter debounce and edge pulse
// Optional hold-to-repeat pulses under BTN_PULSE_AUTOREPEAT_EN.
module btn_debounce_ch
    import btn_pulse_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = EDGE_RISE,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_pulse
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   w_sync;
    logic                   w_flip;
    logic                   w_edge_hit;
    logic                   w_rep_hit;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_flip     = (w_sync != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
    assign w_edge_hit = w_flip && ((EDGE_MODE == EDGE_BOTH) || ((EDGE_MODE == EDGE_RISE) == w_sync));
    assign o_level    = r_level;
    assign o_pulse    = r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_btn};
            r_cnt   <= (w_sync == r_level || w_flip) ? '0 : r_cnt + 1'b1;
            r_level <= w_flip ? w_sync : r_level;
            r_pulse <= w_edge_hit || w_rep_hit;
        end
    end

`ifdef BTN_PULSE_AUTOREPEAT_EN
    localparam int HW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

    logic [HW-1:0] r_hold;
    logic          r_rep;

    // r_rep selects the initial hold delay or the steady repeat period
    assign w_rep_hit = (EDGE_MODE != EDGE_FALL) && r_level && !w_flip &&
                       (r_hold == (r_rep ? HW'(REPEAT_PERIOD - 1) : HW'(REPEAT_DELAY - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
        end else if (w_flip || !r_level) begin
            r_hold <= '0;
            r_rep  <= 1'b0;
        end else if (w_rep_hit) begin
            r_hold <= '0;
            r_rep  <= 1'b1;
        end else begin
            r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_rep_hit = 1'b0 & (REPEAT_DELAY != REPEAT_PERIOD);
`endif
endmodule

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: N_CH debounced button channels with edge pulses and any-pulse flag
// Auto-repeat is enabled by defining BTN_PULSE_AUTOREPEAT_EN.
module btn_pulse_gen
    import btn_pulse_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = EDGE_RISE,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] pulse,
    output logic            any_pulse
);
    logic r_any;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_MODE      (EDGE_MODE),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (btn_in[i]),
            .o_level(btn_level[i]),
            .o_pulse(pulse[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_any <= 1'b0;
        else        r_any <= |pulse;
    end

    assign any_pulse = r_any;
endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: three DUTs (rise/fall/both) against a sample-window reference model
module tb_btn_pulse_gen;
    localparam int NC = 4, SS = 2, DC = 4, RD = 10, RP = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [NC-1:0] btn_in = '0;
    logic [NC-1:0] lv[3];
    logic [NC-1:0] pl[3];
    logic          an[3];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    for (genvar m = 0; m < 3; m++) begin : g_dut
        btn_pulse_gen #(
            .N_CH(NC), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
            .EDGE_MODE(m), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
        ) dut (
            .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
            .btn_level(lv[m]), .pulse(pl[m]), .any_pulse(an[m])
        );
    end

    // Reference: a level is accepted once the last DC synchronised samples all disagree with it.
    logic [NC-1:0] pipe[$];
    logic [NC-1:0] shist[$];
    logic [NC-1:0] m_s;
    logic [NC-1:0] m_lvl[3];
    logic [NC-1:0] m_pul[3];
    logic          m_any[3];
    int            m_rise[3][NC];
    int            m_d;
    int            tcount;
    bit            st;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.delete();
            shist.delete();
            repeat (SS) pipe.push_back('0);
            repeat (DC) shist.push_back('0);
            tcount = 0;
            for (int m = 0; m < 3; m++) begin
                m_lvl[m] = '0;
                m_pul[m] = '0;
                m_any[m] = 1'b0;
            end
        end else begin
            tcount++;
            m_s = pipe.pop_front();
            pipe.push_back(btn_in);
            shist.delete(0);
            shist.push_back(m_s);
            for (int m = 0; m < 3; m++) begin
                m_any[m] = |m_pul[m];
                for (int c = 0; c < NC; c++) begin
                    st = 1;
                    foreach (shist[k]) if (shist[k][c] == m_lvl[m][c]) st = 0;
                    m_pul[m][c] = 1'b0;
                    if (st) begin
                        m_lvl[m][c] = ~m_lvl[m][c];
                        m_pul[m][c] = (m == 2) || (m == 0 && m_lvl[m][c]) || (m == 1 && !m_lvl[m][c]);
                        if (m_lvl[m][c]) m_rise[m][c] = tcount;
                    end
`ifdef BTN_PULSE_AUTOREPEAT_EN
                    else if (m != 1 && m_lvl[m][c]) begin
                        m_d = tcount - m_rise[m][c];
                        m_pul[m][c] = (m_d >= RD) && ((m_d - RD) % RP == 0);
                    end
`endif
                end
            end
        end
    end

    logic [26:0] obs, expv;
    assign obs  = {lv[0], pl[0], an[0], lv[1], pl[1], an[1], lv[2], pl[2], an[2]};
    assign expv = {m_lvl[0], m_pul[0], m_any[0], m_lvl[1], m_pul[1], m_any[1], m_lvl[2], m_pul[2], m_any[2]};

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL reset_async: got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL reset_idle: got %h expected %h", obs, expv); end
        end
    endtask

    task automatic test_clean_press;
        int first_p = 0, first_l = 0, anyc = 0, anyat = 0;
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL clean_press k=%0d: got %h expected %h", k, obs, expv); end
            if (pl[0][0] && first_p == 0) first_p = k;
            if (lv[0][0] && first_l == 0) first_l = k;
            if (an[0]) begin anyc++; anyat = k; end
        end
        n_cmp++;
        if (first_p !== 6 || first_l !== 6) begin n_bad++; $display("FAIL clean_latency: got pulse@%0d level@%0d expected 6", first_p, first_l); end
        n_cmp++;
        if (anyc !== 1 || anyat !== 7) begin n_bad++; $display("FAIL clean_any: got %0d@%0d expected 1@7", anyc, anyat); end
        btn_in[0] = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL clean_release: got %h expected %h", obs, expv); end
        end
    endtask

    task automatic test_glitch;
        int first_p = 0;
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL glitch k=%0d: got %h expected %h", k, obs, expv); end
            if (k == 3) btn_in[1] = 1'b0;
        end
        btn_in[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL glitch_repress k=%0d: got %h expected %h", k, obs, expv); end
            if ((pl[0][1] || lv[0][1]) && first_p == 0) first_p = k;
        end
        n_cmp++;
        if (first_p !== 6) begin n_bad++; $display("FAIL glitch_cleared: got first level/pulse@%0d expected 6", first_p); end
        btn_in[1] = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL glitch_release: got %h expected %h", obs, expv); end
        end
    endtask

    task automatic test_edge_modes;
        int cnt[3] = '{0, 0, 0};
        int fall_at = 0;
        btn_in[2] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL edge_modes k=%0d: got %h expected %h", k, obs, expv); end
            for (int m = 0; m < 3; m++) if (pl[m][2]) cnt[m]++;
            if (pl[1][2] && fall_at == 0) fall_at = k;
            if (k == 8) btn_in[2] = 1'b0;
        end
        n_cmp++;
        if (cnt[0] !== 1 || cnt[1] !== 1 || cnt[2] !== 2) begin
            n_bad++; $display("FAIL edge_counts: got %0d/%0d/%0d expected 1/1/2", cnt[0], cnt[1], cnt[2]);
        end
        n_cmp++;
        if (fall_at !== 14) begin n_bad++; $display("FAIL fall_latency: got %0d expected 14", fall_at); end
    endtask

    task automatic test_reset_mid;
        int first_p = 0;
        logic [NC-1:0] pv = '0;
        btn_in[3] = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL rst_pre: got %h expected %h", obs, expv); end
        end
        btn_in[2] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL rst_count: got %h expected %h", obs, expv); end
        end
        n_cmp++;
        if (lv[0] !== 4'b1000) begin n_bad++; $display("FAIL rst_prelevel: got %b expected 1000", lv[0]); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== '0) begin n_bad++; $display("FAIL rst_mid_async: got %h expected 0", obs); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL rst_post k=%0d: got %h expected %h", k, obs, expv); end
            if (pl[0] != '0 && first_p == 0) begin first_p = k; pv = pl[0]; end
        end
        n_cmp++;
        if (first_p !== 6 || pv !== 4'b1100) begin n_bad++; $display("FAIL rst_held_pulse: got %b@%0d expected 1100@6", pv, first_p); end
        btn_in = '0;
        repeat (12) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL rst_release: got %h expected %h", obs, expv); end
        end
    endtask

    task automatic test_simultaneous;
        logic [NC-1:0] p6 = '0;
        int anyc = 0, anyat = 0;
        btn_in = 4'b1001;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL simul k=%0d: got %h expected %h", k, obs, expv); end
            if (k == 6) p6 = pl[0];
            if (an[0]) begin anyc++; anyat = k; end
        end
        n_cmp++;
        if (p6 !== 4'b1001) begin n_bad++; $display("FAIL simul_pulse: got %b expected 1001", p6); end
        n_cmp++;
        if (anyc !== 1 || anyat !== 7) begin n_bad++; $display("FAIL simul_any: got %0d@%0d expected 1@7", anyc, anyat); end
        btn_in = '0;
        repeat (12) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL simul_release: got %h expected %h", obs, expv); end
        end
    endtask

    task automatic test_autorepeat;
        int cnt[3] = '{0, 0, 0};
`ifdef BTN_PULSE_AUTOREPEAT_EN
        int want[3] = '{8, 1, 9};
`else
        int want[3] = '{1, 1, 2};
`endif
        btn_in[0] = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL repeat k=%0d: got %h expected %h", k, obs, expv); end
            for (int m = 0; m < 3; m++) if (pl[m][0]) cnt[m]++;
            if (k == 30) btn_in[0] = 1'b0;
        end
        n_cmp++;
        if (cnt[0] !== want[0] || cnt[1] !== want[1] || cnt[2] !== want[2]) begin
            n_bad++; $display("FAIL repeat_counts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                              cnt[0], cnt[1], cnt[2], want[0], want[1], want[2]);
        end
    endtask

    task automatic test_random;
        int hold[NC];
        for (int c = 0; c < NC; c++) hold[c] = $urandom_range(1, 9);
        repeat (400) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL random t=%0d: got %h expected %h", tcount, obs, expv); end
            for (int c = 0; c < NC; c++) begin
                hold[c]--;
                if (hold[c] == 0) begin
                    btn_in[c] = ~btn_in[c];
                    hold[c] = $urandom_range(1, 9);
                end
            end
        end
        btn_in = '0;
        repeat (12) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs !== expv) begin n_bad++; $display("FAIL random_release: got %h expected %h", obs, expv); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_clean_press();
        test_glitch();
        test_edge_modes();
        test_reset_mid();
        test_simultaneous();
        test_autorepeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
